// File: rtl/spec_sched_pkg.sv
// Shared types for the spectral frame scheduler: FSM states, bank index, default sizes.
// Imported by the scheduler, its bank tracker and the bus interface.
package spec_sched_pkg;
    localparam int FFT_N_DEF  = 1024;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    typedef logic bank_t;
endpackage

// File: rtl/spec_frame_sched_if.sv
// Scheduler-facing signal bundle: writer handshake, separation engine, display port, RAM read port.
// master is the scheduler side, slave is the surrounding datapath.
interface spec_frame_sched_if import spec_sched_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OVR_W  = 8
);
    logic              wr_frame_done;
    bank_t             wr_bank;
    logic              ifft_ready;
    logic              sep_enable;
    logic [ADDR_W-1:0] sep_addr;
    logic              sep_tlast;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [ADDR_W:0]   ram_rd_addr;
    logic              ram_rd_en;
    logic              busy;
    logic [OVR_W-1:0]  overrun_cnt;
    logic              tlast_err;

    modport master (
        input  wr_frame_done, ifft_ready, sep_addr, sep_tlast, disp_req, disp_addr,
        output wr_bank, sep_enable, disp_gnt, disp_rvalid, ram_rd_addr, ram_rd_en,
               busy, overrun_cnt, tlast_err
    );

    modport slave (
        output wr_frame_done, ifft_ready, sep_addr, sep_tlast, disp_req, disp_addr,
        input  wr_bank, sep_enable, disp_gnt, disp_rvalid, ram_rd_addr, ram_rd_en,
               busy, overrun_cnt, tlast_err
    );
endinterface

// File: rtl/spec_bank_tracker.sv
// Ping-pong bank bookkeeping: full flags, writer bank and saturating overrun count.
// Updates on the edge after wr_frame_done/rel; a release is applied before the writer's decision.
module spec_bank_tracker import spec_sched_pkg::*; #(
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_frame_done,
    input  logic             lock,
    input  logic             rel,
    input  bank_t            rd_bank,
    output bank_t            wr_bank,
    output logic [1:0]       full,
    output logic [OVR_W-1:0] overrun_cnt
);
    logic [1:0] full_rel;
    bank_t      other;
    logic       toggle;

    always_comb begin
        full_rel = full;
        if (rel) full_rel[rd_bank] = 1'b0;
        other  = ~wr_bank;
        // The writer may move onto the other bank only if it holds no unread frame
        // and the reader is not on it, unless the reader gives it up this very cycle.
        toggle = (!full_rel[other] && !(lock && rd_bank == other)) ||
                 (rel && rd_bank == other);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full        <= 2'b00;
            wr_bank     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            full <= full_rel;
            if (wr_frame_done) begin
                full[wr_bank] <= 1'b1;
                if (full_rel[wr_bank] && overrun_cnt != '1)
                    overrun_cnt <= overrun_cnt + OVR_W'(1);
                if (toggle)
                    wr_bank <= other;
            end
        end
    end
endmodule

// File: rtl/spec_frame_sched.sv
// Frame scheduler: opens a FFT_N-cycle separation window on a full bank, waits for tlast, and
// lends the RAM read port to the display whenever no window is open (display data is best effort).
module spec_frame_sched import spec_sched_pkg::*; #(
    parameter int FFT_N    = FFT_N_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int TLAST_TO = 16,
    parameter int OVR_W    = 8
) (
    input logic               clk,
    input logic               rst,
    spec_frame_sched_if.master bus
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FFT_N - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TLAST_TO - 1);

    sched_state_t    state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   to;
    bank_t           rd_bank;
    bank_t           last_bank;
    bank_t           wr_bank;
    logic [1:0]      full;
    logic            sep_en_q;
    logic            busy_q;
    logic            tlast_err_q;
    logic            rvalid_q;
    logic            rel;
    logic            gnt;
    logic [ADDR_W:0] rd_addr;
    logic            rd_en;

    assign rel = (state == DRAIN) && (bus.sep_tlast || to == TO_LAST);
    assign gnt = bus.disp_req && (state != RUN) && !rst;

    spec_bank_tracker #(.OVR_W(OVR_W)) u_banks (
        .clk          (clk),
        .rst          (rst),
        .wr_frame_done(bus.wr_frame_done),
        .lock         (state != IDLE),
        .rel          (rel),
        .rd_bank      (rd_bank),
        .wr_bank      (wr_bank),
        .full         (full),
        .overrun_cnt  (bus.overrun_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            to          <= '0;
            rd_bank     <= 1'b0;
            last_bank   <= 1'b0;
            sep_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            tlast_err_q <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            rvalid_q <= gnt;
            case (state)
                IDLE: begin
                    if (full[~wr_bank] && bus.ifft_ready) begin
                        state    <= RUN;
                        rd_bank  <= ~wr_bank;
                        cnt      <= '0;
                        sep_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state    <= DRAIN;
                        to       <= '0;
                        sep_en_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    to <= to + CW'(1);
                    if (rel) begin
                        state     <= IDLE;
                        last_bank <= rd_bank;
                        busy_q    <= 1'b0;
                        if (!bus.sep_tlast) tlast_err_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The separator owns the read port for the whole window; the display only gets leftovers.
    always_comb begin
        rd_addr = {last_bank, bus.disp_addr};
        rd_en   = gnt;
        if (state == RUN) begin
            rd_addr = {rd_bank, bus.sep_addr};
            rd_en   = 1'b1;
        end
    end

    assign bus.wr_bank     = wr_bank;
    assign bus.sep_enable  = sep_en_q;
    assign bus.busy        = busy_q;
    assign bus.tlast_err   = tlast_err_q;
    assign bus.disp_gnt    = gnt;
    assign bus.disp_rvalid = rvalid_q;
    assign bus.ram_rd_addr = rd_addr;
    assign bus.ram_rd_en   = rd_en;
endmodule

// File: tb/tb_spec_frame_sched.sv
// Randomized bench for spec_frame_sched: a cycle-count frame model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_spec_frame_sched;
    import spec_sched_pkg::*;

    localparam int FFT_N    = 1024;
    localparam int ADDR_W   = 10;
    localparam int TLAST_TO = 16;
    localparam int OVR_W    = 8;
    localparam int OVR_MAX  = (1 << OVR_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spec_frame_sched_if #(.ADDR_W(ADDR_W), .OVR_W(OVR_W)) bus ();

    spec_frame_sched #(
        .FFT_N(FFT_N), .ADDR_W(ADDR_W), .TLAST_TO(TLAST_TO), .OVR_W(OVR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: frames described by their start cycle ----------------
    bit     m_full [2] = '{1'b0, 1'b0};
    bit     m_wr = 1'b0, m_rd = 1'b0, m_last = 1'b0, m_err = 1'b0;
    bit     m_active = 1'b0, m_prev_gnt = 1'b0;
    int     m_ovr = 0;
    longint cyc = 0, m_start = 0;

    function automatic bit en_exp();
        return m_active && cyc >= m_start && cyc < m_start + FFT_N;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit     rel, start, other, gnt_now;
        longint d;
        if (rst) begin
            m_full[0] = 1'b0; m_full[1] = 1'b0;
            m_wr = 1'b0; m_rd = 1'b0; m_last = 1'b0; m_err = 1'b0;
            m_active = 1'b0; m_prev_gnt = 1'b0; m_ovr = 0;
        end else begin
            gnt_now = bus.disp_req && !en_exp();
            rel = 1'b0;
            if (m_active && cyc >= m_start + FFT_N) begin
                d = cyc - (m_start + FFT_N);
                if (bus.sep_tlast || d == TLAST_TO - 1) begin
                    rel = 1'b1;
                    if (!bus.sep_tlast) m_err = 1'b1;
                    m_last = m_rd;
                    m_full[m_rd] = 1'b0;
                end
            end
            start = !m_active && m_full[!m_wr] && bus.ifft_ready;
            if (start) m_rd = !m_wr;
            if (bus.wr_frame_done) begin
                if (m_full[m_wr] && m_ovr < OVR_MAX) m_ovr++;
                m_full[m_wr] = 1'b1;
                other = !m_wr;
                if (!m_full[other] && !(m_active && !rel && m_rd == other)) m_wr = other;
            end
            if (rel) m_active = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_start  = cyc + 1;
            end
            m_prev_gnt = gnt_now;
        end
        if (!rst || $rose(clk)) cyc++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit e, g;
        e = en_exp();
        g = !rst && bus.disp_req && !e;
        check("sep_enable",  bus.sep_enable,  e);
        check("busy",        bus.busy,        m_active);
        check("wr_bank",     bus.wr_bank,     m_wr);
        check("overrun_cnt", bus.overrun_cnt, m_ovr);
        check("tlast_err",   bus.tlast_err,   m_err);
        check("disp_gnt",    bus.disp_gnt,    g);
        check("disp_rvalid", bus.disp_rvalid, m_prev_gnt);
        check("ram_rd_en",   bus.ram_rd_en,   e || g);
        if (e)      check("ram_addr_sep",  bus.ram_rd_addr, {m_rd, bus.sep_addr});
        else if (g) check("ram_addr_disp", bus.ram_rd_addr, {m_last, bus.disp_addr});
    end

    // ---------------- stimulus ----------------
    int tl_delay = 3;
    int tl_cnt   = -1;
    bit prev_en  = 1'b0;
    bit disp_force = 1'b0;
    bit noise_en = 1'b1;

    // window statistics sampled on the stimulus side
    int k, first_k, win_cnt, en_len, gap, min_gap, gnt_run, gnt_idle;
    bit win_bank[$];
    bit mon_prev;

    task automatic stats_clear();
        k = -1; first_k = -1; win_cnt = 0; en_len = 0; gap = 0;
        min_gap = 1 << 30; gnt_run = 0; gnt_idle = 0; mon_prev = 1'b0;
        win_bank.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        k++;
        bus.wr_frame_done = 1'b0;
        bus.sep_addr  = ADDR_W'($urandom);
        bus.disp_addr = ADDR_W'($urandom);
        bus.disp_req  = disp_force ? 1'b1 : ($urandom % 3 == 0);
        bus.sep_tlast = 1'b0;
        if (bus.sep_enable) begin
            bus.sep_tlast = noise_en && ($urandom % 64 == 0);
        end else begin
            if (prev_en) tl_cnt = tl_delay;
            if (tl_cnt == 0) bus.sep_tlast = 1'b1;
            if (tl_cnt >= 0) tl_cnt--;
        end
        prev_en = bus.sep_enable;
        if (bus.sep_enable) begin
            if (!mon_prev) begin
                win_bank.push_back(bus.ram_rd_addr[ADDR_W]);
                if (win_cnt > 0 && gap < min_gap) min_gap = gap;
                if (first_k < 0) first_k = k;
                win_cnt++;
                en_len = 0;
            end
            en_len++;
            gap = 0;
            if (bus.disp_gnt) gnt_run++;
        end else begin
            gap++;
            if (bus.disp_gnt) gnt_idle++;
        end
        mon_prev = bus.sep_enable;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse();
        step();
        bus.wr_frame_done = 1'b1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tl_cnt = -1;
        prev_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_frame_done = 1'b0;
        bus.ifft_ready    = 1'b0;
        bus.sep_addr      = '0;
        bus.sep_tlast     = 1'b0;
        bus.disp_req      = 1'b0;
        bus.disp_addr     = '0;

        // reset state
        do_reset();
        check("rst_wr_bank",   bus.wr_bank,     0);
        check("rst_overrun",   bus.overrun_cnt, 0);
        check("rst_tlast_err", bus.tlast_err,   0);
        check("rst_busy",      bus.busy,        0);
        check("rst_sep_en",    bus.sep_enable,  0);

        // single frame
        bus.ifft_ready = 1'b1; tl_delay = 3; noise_en = 1'b1;
        stats_clear();
        pulse();
        step();
        check("single_wr_bank_toggled", bus.wr_bank, 1);
        run_steps(1199);
        check("single_windows",  win_cnt, 1);
        check("single_en_len",   en_len,  FFT_N);
        check("single_start",    first_k, 2);
        if (win_cnt > 0) check("single_rd_bank", win_bank[0], 0);
        check("single_busy_end", bus.busy, 0);

        // back-to-back frames
        do_reset();
        stats_clear();
        pulse();
        run_steps(1100);
        pulse();
        run_steps(1100);
        check("b2b_windows", win_cnt, 2);
        if (win_cnt == 2) begin
            check("b2b_bank0", win_bank[0], 0);
            check("b2b_bank1", win_bank[1], 1);
        end
        check("b2b_gap_ge2", min_gap >= 2, 1);
        check("b2b_overrun", bus.overrun_cnt, 0);

        // overrun with the IFFT stalled
        do_reset();
        bus.ifft_ready = 1'b0;
        stats_clear();
        pulse(); run_steps(3);
        pulse(); run_steps(3);
        pulse(); run_steps(20);
        check("ovr_count",   bus.overrun_cnt, 1);
        check("ovr_wr_bank", bus.wr_bank,     1);
        check("ovr_no_win",  win_cnt,         0);
        bus.ifft_ready = 1'b1; tl_delay = 2;
        run_steps(1100);

        // tlast timeout with display held on
        do_reset();
        bus.ifft_ready = 1'b1; tl_delay = -1; noise_en = 1'b0; disp_force = 1'b1;
        stats_clear();
        pulse();
        run_steps(1100);
        check("to_tlast_err",  bus.tlast_err, 1);
        check("to_busy",       bus.busy,      0);
        check("to_windows",    win_cnt,       1);
        check("arb_gnt_run",   gnt_run,       0);
        check("arb_gnt_idle",  gnt_idle > 0,  1);
        disp_force = 1'b0; noise_en = 1'b1;

        // reset in the middle of a window
        do_reset();
        tl_delay = 3;
        stats_clear();
        pulse();
        for (int i = 0; i < 600 && en_len < 500; i++) step();
        check("mid_reached_500", en_len, 500);
        rst = 1'b1;
        #1;
        check("mid_sep_en_async", bus.sep_enable, 0);
        check("mid_busy_async",   bus.busy,       0);
        step(); step();
        rst = 1'b0;
        tl_cnt = -1;
        run_steps(20);
        check("mid_wr_bank",  bus.wr_bank,     0);
        check("mid_overrun",  bus.overrun_cnt, 0);
        check("mid_no_restart", win_cnt,       1);

        // randomized traffic
        do_reset();
        stats_clear();
        for (int i = 0; i < 12000; i++) begin
            if (i % 500 == 0)
                tl_delay = ($urandom % 4 == 0) ? -1 : int'($urandom_range(0, 14));
            step();
            if ($urandom % 200 == 0) bus.ifft_ready = ~bus.ifft_ready;
            if ($urandom % 300 == 0) bus.wr_frame_done = 1'b1;
        end
        check("rand_gap_ge2", (win_cnt < 2) || (min_gap >= 2), 1);
        run_steps(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
